// File: rtl/alarm_pkg.sv
// Shared state encodings and counter widths for the alarm response controller.
package alarm_pkg;

  localparam int unsigned COUNT_W   = 8;
  localparam int unsigned COUNT_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GRACE    = 2'b01,
    ST_ALARM    = 2'b10,
    ST_SILENCED = 2'b11
  } state_e;

endpackage

// File: rtl/alarm_blink_gen.sv
// Status LED blinker: square wave of 2*BLINK_HALF cycles, high half first, restarted on each
// rising edge of en and held low while en is low.
module alarm_blink_gen
  import alarm_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic led_q
);

  localparam logic [COUNT_W-1:0] Reload = COUNT_W'(BLINK_HALF - 1);

  logic               en_q;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               led_d;

  always_comb begin
    cnt_d = cnt_q;
    led_d = led_q;
    if (!en) begin
      cnt_d = '0;
      led_d = 1'b0;
    end else if (!en_q) begin
      cnt_d = Reload;
      led_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d = Reload;
      led_d = ~led_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    assert (BLINK_HALF >= 1 && BLINK_HALF <= COUNT_MAX)
      else $error("BLINK_HALF out of range 1..255");
    if (rst) begin
      en_q  <= 1'b0;
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      en_q  <= en;
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

endmodule

// File: rtl/alarm_response_ctrl.sv
// Alarm response FSM: entry grace period, latched alarm with siren and blinking LED,
// key silencing, and a saturating count of alarm entries.
module alarm_response_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned GRACE_CYCLES = 16,
  parameter int unsigned BLINK_HALF   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alarm_req,
  input  logic                 key_ok,
  output logic                 siren,
  output logic                 led,
  output logic [1:0]           state_o,
  output logic [COUNT_W-1:0]   alarm_count
);

  localparam logic [COUNT_W-1:0] GraceLoad = COUNT_W'(GRACE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CountSat  = COUNT_W'(COUNT_MAX);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] grace_q, grace_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               blink_led;
  logic               blink_en;

  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (alarm_req && !key_ok) begin
          state_d = ST_GRACE;
          grace_d = GraceLoad;
        end
      end
      ST_GRACE: begin
        // Key wins over expiry on the same edge; request is latched once in GRACE.
        if (key_ok) begin
          state_d = ST_IDLE;
        end else if (grace_q == '0) begin
          state_d = ST_ALARM;
          if (count_q != CountSat) begin
            count_d = count_q + 1'b1;
          end
        end else begin
          grace_d = grace_q - 1'b1;
        end
      end
      ST_ALARM: begin
        if (key_ok) begin
          state_d = ST_SILENCED;
        end
      end
      ST_SILENCED: begin
        if (!alarm_req && !key_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    assert (GRACE_CYCLES >= 1 && GRACE_CYCLES <= COUNT_MAX)
      else $error("GRACE_CYCLES out of range 1..255");
    if (rst) begin
      state_q <= ST_IDLE;
      grace_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grace_q <= grace_d;
      count_q <= count_d;
    end
  end

  // Driven from next state so the blinker loads on the same edge that enters ALARM.
  assign blink_en = (state_d == ST_ALARM);

  alarm_blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk   (clk),
    .rst   (rst),
    .en    (blink_en),
    .led_q (blink_led)
  );

  always_comb begin
    siren = 1'b0;
    led   = 1'b0;
    unique case (state_q)
      ST_ALARM: begin
        siren = 1'b1;
        led   = blink_led;
      end
      ST_SILENCED: led = 1'b1;
      default: ;
    endcase
  end

  assign state_o     = state_q;
  assign alarm_count = count_q;

endmodule

// File: tb/tb_alarm_response_ctrl.sv
// Bench for alarm_response_ctrl: directed scenarios plus random stimulus against an
// event-level reference model.
module tb_alarm_response_ctrl;

  localparam int unsigned GraceCycles = 4;
  localparam int unsigned BlinkHalf   = 2;

  localparam int MIdle     = 0;
  localparam int MGrace    = 1;
  localparam int MAlarm    = 2;
  localparam int MSilenced = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       alarm_req;
  logic       key_ok;
  logic       siren;
  logic       led;
  logic [1:0] state_o;
  logic [7:0] alarm_count;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, cycles spent in grace, cycles spent in alarm, entry count.
  int m_mode    = MIdle;
  int m_spent   = 0;
  int m_alarm_t = 0;
  int m_count   = 0;

  alarm_response_ctrl #(
    .GRACE_CYCLES (GraceCycles),
    .BLINK_HALF   (BlinkHalf)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alarm_req   (alarm_req),
    .key_ok      (key_ok),
    .siren       (siren),
    .led         (led),
    .state_o     (state_o),
    .alarm_count (alarm_count)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    if (rst) begin
      m_mode  = MIdle;
      m_count = 0;
    end else begin
      case (m_mode)
        MIdle: if (alarm_req && !key_ok) begin
          m_mode  = MGrace;
          m_spent = 0;
        end
        MGrace: begin
          if (key_ok) begin
            m_mode = MIdle;
          end else begin
            m_spent++;
            if (m_spent == GraceCycles) begin
              m_mode    = MAlarm;
              m_alarm_t = 0;
              m_count   = (m_count < 255) ? m_count + 1 : 255;
            end
          end
        end
        MAlarm: if (key_ok) m_mode = MSilenced; else m_alarm_t++;
        MSilenced: if (!alarm_req && !key_ok) m_mode = MIdle;
        default: m_mode = MIdle;
      endcase
    end
  endtask

  // Expected {siren, led, state, count}.
  function automatic logic [11:0] model_out();
    logic       s;
    logic       l;
    logic [1:0] st;
    logic [7:0] c;
    s  = (m_mode == MAlarm);
    l  = (m_mode == MSilenced) ||
         ((m_mode == MAlarm) && (((m_alarm_t / BlinkHalf) % 2) == 0));
    st = m_mode[1:0];
    c  = m_count[7:0];
    return {s, l, st, c};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alarm_req = 1'b1; key_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({siren, led, state_o, alarm_count} !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %b required %b", i,
                 {siren, led, state_o, alarm_count}, 12'h000);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if ({siren, led, state_o, alarm_count} !== model_out()) begin
      errors++;
      $display("FAIL reset_release: got %b required %b",
               {siren, led, state_o, alarm_count}, model_out());
    end
  endtask

  task automatic test_grace_expiry();
    logic [1:0] exp_st [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic       exp_led [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    alarm_req = 1'b1; key_ok = 1'b0;
    step();
    alarm_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (state_o !== exp_st[i] || led !== exp_led[i] || siren !== (exp_st[i] == 2'b10)) begin
        errors++;
        $display("FAIL grace_expiry cyc %0d: got st=%b led=%b siren=%b required st=%b led=%b",
                 i, state_o, led, siren, exp_st[i], exp_led[i]);
      end
      checks++;
      if ({siren, led, state_o, alarm_count} !== model_out()) begin
        errors++;
        $display("FAIL grace_model cyc %0d: got %b required %b", i,
                 {siren, led, state_o, alarm_count}, model_out());
      end
      step();
    end
    checks++;
    if (alarm_count !== 8'd1) begin
      errors++;
      $display("FAIL grace_count: got %0d required 1", alarm_count);
    end
  endtask

  task automatic test_disarm();
    key_ok = 1'b1; step();
    key_ok = 1'b0; step();
    alarm_req = 1'b1; step();
    alarm_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({siren, led, state_o, alarm_count} !== model_out()) begin
        errors++;
        $display("FAIL disarm_grace cyc %0d: got %b required %b", i,
                 {siren, led, state_o, alarm_count}, model_out());
      end
    end
    key_ok = 1'b1;
    step();
    checks++;
    if (state_o !== 2'b00 || siren !== 1'b0 || alarm_count !== 8'd1) begin
      errors++;
      $display("FAIL disarm_expiry_edge: got st=%b siren=%b cnt=%0d required st=00 siren=0 cnt=1",
               state_o, siren, alarm_count);
    end
    key_ok = 1'b0;
    step();
  endtask

  task automatic test_silence_rearm();
    rst = 1'b1; step();
    rst = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      alarm_req = 1'b1; key_ok = 1'b0; step();
      alarm_req = 1'b0;
      for (int i = 0; i < GraceCycles + 3; i++) step();
      key_ok = 1'b1; step();
      checks++;
      if ({siren, led, state_o} !== 4'b0111) begin
        errors++;
        $display("FAIL silence rep %0d: got %b required 0111", rep, {siren, led, state_o});
      end
      alarm_req = 1'b1; key_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        checks++;
        if ({siren, led, state_o, alarm_count} !== model_out()) begin
          errors++;
          $display("FAIL silence_hold rep %0d cyc %0d: got %b required %b", rep, i,
                   {siren, led, state_o, alarm_count}, model_out());
        end
      end
      alarm_req = 1'b0; step();
      checks++;
      if (state_o !== 2'b00) begin
        errors++;
        $display("FAIL silence_release rep %0d: got %b required 00", rep, state_o);
      end
    end
    checks++;
    if (alarm_count !== 8'd2) begin
      errors++;
      $display("FAIL rearm_count: got %0d required 2", alarm_count);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      alarm_req = ($urandom_range(0, 3) != 0);
      key_ok    = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
      checks++;
      if ({siren, led, state_o, alarm_count} !== model_out()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b required %b", i,
                 {siren, led, state_o, alarm_count}, model_out());
      end
    end
    rst = 1'b0; alarm_req = 1'b0; key_ok = 1'b0;
  endtask

  task automatic test_reset_mid_alarm();
    rst = 1'b1; step();
    rst = 1'b0; alarm_req = 1'b1; key_ok = 1'b0; step();
    alarm_req = 1'b0;
    for (int i = 0; i < GraceCycles + 2; i++) step();
    checks++;
    if (state_o !== 2'b10 || led !== 1'b0) begin
      errors++;
      $display("FAIL mid_alarm_led_low: got st=%b led=%b required st=10 led=0", state_o, led);
    end
    rst = 1'b1; step();
    checks++;
    if ({siren, led, state_o, alarm_count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_alarm: got %b required %b",
               {siren, led, state_o, alarm_count}, 12'h000);
    end
    rst = 1'b0; alarm_req = 1'b1; step();
    alarm_req = 1'b0;
    for (int i = 0; i < GraceCycles; i++) step();
    checks++;
    if ({siren, led, state_o, alarm_count} !== {1'b1, 1'b1, 2'b10, 8'd1}) begin
      errors++;
      $display("FAIL reentry_led: got %b required %b",
               {siren, led, state_o, alarm_count}, {1'b1, 1'b1, 2'b10, 8'd1});
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1; alarm_req = 1'b0; key_ok = 1'b0; step();
    rst = 1'b0;
    for (int n = 1; n <= 257; n++) begin
      alarm_req = 1'b1; key_ok = 1'b0; step();
      alarm_req = 1'b0;
      for (int i = 0; i < GraceCycles; i++) step();
      checks++;
      if (state_o !== 2'b10 || alarm_count !== 8'((n > 255) ? 255 : n)) begin
        errors++;
        $display("FAIL saturation entry %0d: got st=%b cnt=%0d required st=10 cnt=%0d",
                 n, state_o, alarm_count, (n > 255) ? 255 : n);
      end
      key_ok = 1'b1; step();
      key_ok = 1'b0; step();
    end
    checks++;
    if ({siren, led, state_o, alarm_count} !== {4'b0000, 8'd255}) begin
      errors++;
      $display("FAIL saturation_final: got %b required %b",
               {siren, led, state_o, alarm_count}, {4'b0000, 8'd255});
    end
  endtask

  initial begin
    rst = 1'b1; alarm_req = 1'b0; key_ok = 1'b0;
    test_reset();
    test_grace_expiry();
    test_disarm();
    test_silence_rearm();
    test_random();
    test_reset_mid_alarm();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
